cond_code_gen: RTL and testbench
================================

COND_CODE_GEN -- requirements
Module: cond_code_gen

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: a_in  input  16  compare operand A.
REQ-004 SHALL: b_in  input  16  compare operand B.
REQ-005 SHALL: cmp_valid  input  1  compare instruction present in EX this cycle.
REQ-006 SHALL: signed_cmp  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-007 SHALL: stall  input  1  pipeline hold; all internal state frozen.
REQ-008 SHALL: flush  input  1  branch-taken squash from branch resolution unit.
REQ-009 SHALL: branch_req  input  1  branch instruction in decode needs condition codes.
REQ-010 SHALL: EQ, LT, GT, LE, GE, NE  output  1 each  registered condition codes, A relative to B.
REQ-011 SHALL: flags_valid  output  1  condition codes reflect at least one completed compare since reset.
REQ-012 SHALL: branch_stall  output  1  interlock, branch must wait for in-flight compare.

Function
REQ-013 SHALL: two-stage pipeline: S1 registers a_in, b_in, signed_cmp, valid; S2 evaluates S1 contents and writes the flag register.
REQ-014 SHALL: latency fixed: cmp_valid sampled at edge N (no stall) -> new flags visible after edge N+2.
REQ-015 SHALL: difference computed 17-bit (zero/sign-extended per signed_cmp); EQ = diff==0; unsigned LT = borrow; signed LT = sign XOR overflow.
REQ-016 SHALL: GT = !LT & !EQ; LE = LT | EQ; GE = !LT; NE = !EQ; exactly one of LT/EQ/GT high after any commit.
REQ-017 SHALL: flag register holds value until next committed compare; no compare -> no change.
REQ-018 SHALL: pending count = number of valid S1/S2 entries (0..2); branch_stall = branch_req & (pending != 0), combinational.
REQ-019 SHALL: stall high -> S1, S2, flag register, flags_valid all hold; cmp_valid ignored.
REQ-020 SHALL: flush high -> S1 valid cleared (younger compare squashed); S2 entry (older) commits normally.
REQ-021 SHALL: flush and cmp_valid same cycle -> new compare dropped, S1 empty after edge.
REQ-022 SHALL: flush and stall same cycle -> flush wins for S1; S2 commits.
REQ-023 SHALL: back-to-back compares -> each commits in order, one cycle apart; final flags from younger.
REQ-024 SHALL: flags_valid set on first commit, cleared only by reset.

Reset
REQ-025 SHALL: rst asserted -> immediately S1/S2 valid = 0, all six flags = 0, flags_valid = 0, branch_stall = 0 (regardless of branch_req).
REQ-026 SHALL: rst mid-operation discards in-flight compares; no commit on the deassertion edge.

Structure
REQ-027 SHALL: shared package holds DATA_WIDTH = 16 and 3-bit branch condition encoding (000 LT, 001 GT, 010 LE, 011 GE, 100 EQ, 101 NE) used by branch resolution unit.
REQ-028 SHALL: combinational compare logic in one sub-module cc_compare (operands, signed_cmp -> six flags); registers stay in cond_code_gen.
REQ-029 SHALL: RTL target 120-400 lines; no latches; no combinational path from a_in/b_in to outputs.

Verification
REQ-030 SHALL: a=5, b=9, signed_cmp=0, cmp_valid one cycle -> 2 edges later LT=LE=NE=1, others 0, flags_valid=1.
REQ-031 SHALL: a=0xFFFF, b=0x0001: signed -> LT=1; unsigned -> GT=1, GE=1; a=b=0x8000 -> EQ=GE=LE=1.
REQ-032 SHALL: signed a=0x7FFF, b=0x8000 (overflow) -> GT=1; a=0x8000, b=0x7FFF -> LT=1.
REQ-033 SHALL: compare at N, branch_req at N+1 -> branch_stall=1 at N+1, N+2; 0 once flags committed.
REQ-034 SHALL: compares C1 (EQ) at N, C2 (LT) at N+1, flush at N+1 -> C1 commits (EQ=1), C2 dropped, flags stay EQ.
REQ-035 SHALL: stall 3 cycles with S1,S2 full -> flags and branch_stall hold; rst mid-stall -> all outputs 0 at once.

Source files
------------

// File: rtl/cond_code_gen_pkg.sv
// ============================================================================
// Module  : cond_code_gen_pkg
// Brief   : Shared definitions for the condition-code generator and the
//           branch resolution unit that consumes its flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_code_gen_pkg;

   localparam int DATA_WIDTH = 16;

   // Branch condition field as decoded by the branch resolution unit
   typedef enum logic [2:0] {
      BR_LT = 3'b000,
      BR_GT = 3'b001,
      BR_LE = 3'b010,
      BR_GE = 3'b011,
      BR_EQ = 3'b100,
      BR_NE = 3'b101
   } br_cond_e;

   // Selects the flag a given branch condition tests; reserved codes never take
   function automatic logic br_cond_true(input br_cond_e cond,
                                         input logic eq, input logic lt,
                                         input logic gt, input logic le,
                                         input logic ge, input logic ne);
      logic r;
      r = 1'b0;
      case (cond)
         BR_LT:   r = lt;
         BR_GT:   r = gt;
         BR_LE:   r = le;
         BR_GE:   r = ge;
         BR_EQ:   r = eq;
         BR_NE:   r = ne;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cond_code_gen_cc_compare.sv
// ============================================================================
// Module  : cc_compare
// Brief   : Purely combinational A-vs-B compare producing six condition flags.
//           A 17-bit difference covers both signed and unsigned operands.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_compare
   import cond_code_gen_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  signed_cmp_i,
   output logic                  eq_o,
   output logic                  lt_o,
   output logic                  gt_o,
   output logic                  le_o,
   output logic                  ge_o,
   output logic                  ne_o
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH:0] a_ext;
   logic [DATA_WIDTH:0] b_ext;
   logic [DATA_WIDTH:0] diff;
   logic                ovf;
   logic                eq;
   logic                lt;

   // Extend operands, subtract, and derive the less-than / equal primitives
   always_comb begin
      a_ext = {signed_cmp_i & a_i[MSB], a_i};
      b_ext = {signed_cmp_i & b_i[MSB], b_i};
      diff  = a_ext - b_ext;
      // Overflow of the 16-bit signed subtraction: operand signs differ and
      // the result sign disagrees with A
      ovf   = (a_i[MSB] ^ b_i[MSB]) & (diff[MSB] ^ a_i[MSB]);
      eq    = (diff == '0);
      // Unsigned: bit 16 is the borrow. Signed: true sign is sign ^ overflow.
      lt    = signed_cmp_i ? (diff[MSB] ^ ovf) : diff[DATA_WIDTH];
   end

   assign eq_o = eq;
   assign lt_o = lt;
   assign gt_o = ~lt & ~eq;
   assign le_o = lt | eq;
   assign ge_o = ~lt;
   assign ne_o = ~eq;

endmodule

`default_nettype wire

// File: rtl/cond_code_gen.sv
// ============================================================================
// Module  : cond_code_gen
// Brief   : Two-stage pipelined compare unit. S1 captures operands, S2 feeds
//           the comparator and commits into a registered flag set. Handles
//           pipeline stall, branch flush and the branch interlock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_code_gen
   import cond_code_gen_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic                  cmp_valid,
   input  logic                  signed_cmp,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  branch_req,
   output logic                  EQ,
   output logic                  LT,
   output logic                  GT,
   output logic                  LE,
   output logic                  GE,
   output logic                  NE,
   output logic                  flags_valid,
   output logic                  branch_stall
);

   // Flag vector order: {EQ, LT, GT, LE, GE, NE}
   logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic                  s1_signed_q, s1_signed_d, s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
   logic                  s2_signed_q, s2_signed_d, s2_valid_q, s2_valid_d;
   logic [5:0]            flags_q, flags_d;
   logic                  flags_valid_q, flags_valid_d;

   logic                  advance;
   logic [1:0]            pending;
   logic                  c_eq, c_lt, c_gt, c_le, c_ge, c_ne;

   cc_compare u_cmp (
      .a_i          (s2_a_q),
      .b_i          (s2_b_q),
      .signed_cmp_i (s2_signed_q),
      .eq_o         (c_eq),
      .lt_o         (c_lt),
      .gt_o         (c_gt),
      .le_o         (c_le),
      .ge_o         (c_ge),
      .ne_o         (c_ne)
   );

   // Next-state for both stages and the flag register
   always_comb begin
      // A flush always lets the older S2 entry retire, even under stall
      advance       = ~stall | flush;

      s1_a_d        = s1_a_q;
      s1_b_d        = s1_b_q;
      s1_signed_d   = s1_signed_q;
      s1_valid_d    = s1_valid_q;
      s2_a_d        = s2_a_q;
      s2_b_d        = s2_b_q;
      s2_signed_d   = s2_signed_q;
      s2_valid_d    = s2_valid_q;
      flags_d       = flags_q;
      flags_valid_d = flags_valid_q;

      if (!stall) begin
         s1_a_d      = a_in;
         s1_b_d      = b_in;
         s1_signed_d = signed_cmp;
         s1_valid_d  = cmp_valid;
      end
      if (flush) begin
         s1_valid_d = 1'b0;
      end

      if (advance) begin
         s2_a_d      = s1_a_q;
         s2_b_d      = s1_b_q;
         s2_signed_d = s1_signed_q;
         // Under flush+stall the stalled S1 entry is squashed, not advanced
         s2_valid_d  = s1_valid_q & ~stall;
         if (s2_valid_q) begin
            flags_d       = {c_eq, c_lt, c_gt, c_le, c_ge, c_ne};
            flags_valid_d = 1'b1;
         end
      end
   end

   // Pipeline and flag registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_a_q        <= '0;
         s1_b_q        <= '0;
         s1_signed_q   <= 1'b0;
         s1_valid_q    <= 1'b0;
         s2_a_q        <= '0;
         s2_b_q        <= '0;
         s2_signed_q   <= 1'b0;
         s2_valid_q    <= 1'b0;
         flags_q       <= '0;
         flags_valid_q <= 1'b0;
      end else begin
         s1_a_q        <= s1_a_d;
         s1_b_q        <= s1_b_d;
         s1_signed_q   <= s1_signed_d;
         s1_valid_q    <= s1_valid_d;
         s2_a_q        <= s2_a_d;
         s2_b_q        <= s2_b_d;
         s2_signed_q   <= s2_signed_d;
         s2_valid_q    <= s2_valid_d;
         flags_q       <= flags_d;
         flags_valid_q <= flags_valid_d;
      end
   end

   // Branch interlock: any compare still in flight blocks a dependent branch
   always_comb begin
      pending      = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
      branch_stall = branch_req & (pending != 2'd0);
   end

   assign EQ          = flags_q[5];
   assign LT          = flags_q[4];
   assign GT          = flags_q[3];
   assign LE          = flags_q[2];
   assign GE          = flags_q[1];
   assign NE          = flags_q[0];
   assign flags_valid = flags_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cond_code_gen.sv
// ============================================================================
// Module  : tb_cond_code_gen
// Brief   : Self-checking bench for cond_code_gen: directed scenarios followed
//           by randomized traffic checked against an in-bench reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_code_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   logic        cmp_valid = 1'b0;
   logic        signed_cmp = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        branch_req = 1'b0;
   logic        EQ, LT, GT, LE, GE, NE, flags_valid, branch_stall;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: each in-flight compare remembers its expected flags
   // and how many advancing edges remain before it lands in the flag register.
   typedef struct {
      logic [5:0] f;
      int         left;
   } ent_t;
   ent_t       q[$];
   logic [5:0] m_flags = '0;
   logic       m_fv    = 1'b0;

   cond_code_gen dut (
      .clk          (clk),
      .rst          (rst),
      .a_in         (a_in),
      .b_in         (b_in),
      .cmp_valid    (cmp_valid),
      .signed_cmp   (signed_cmp),
      .stall        (stall),
      .flush        (flush),
      .branch_req   (branch_req),
      .EQ           (EQ),
      .LT           (LT),
      .GT           (GT),
      .LE           (LE),
      .GE           (GE),
      .NE           (NE),
      .flags_valid  (flags_valid),
      .branch_stall (branch_stall)
   );

   always #5 clk = ~clk;

   // Expected {EQ,LT,GT,LE,GE,NE} from plain integer comparison
   function automatic logic [5:0] ref_cc(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
      longint sa, sb;
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      return {sa == sb, sa < sb, sa > sb, sa <= sb, sa >= sb, sa != sb};
   endfunction

   task automatic model_reset();
      q.delete();
      m_flags = '0;
      m_fv    = 1'b0;
   endtask

   // Apply one rising edge to the model using the inputs present at that edge
   task automatic model_edge();
      ent_t nq[$];
      if (rst) begin
         model_reset();
      end else if (!stall || flush) begin
         foreach (q[i]) begin
            ent_t e;
            e = q[i];
            e.left = e.left - 1;
            if (e.left == 0) begin
               m_flags = e.f;
               m_fv    = 1'b1;
            end else if (!stall) begin
               nq.push_back(e);
            end
         end
         q = nq;
         if (!flush && cmp_valid)
            q.push_back('{ref_cc(a_in, b_in, signed_cmp), 2});
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] dut_flags();
      return {EQ, LT, GT, LE, GE, NE};
   endfunction

   // Advance one clock and compare every output with the model
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, "/flags"}, {2'b00, dut_flags()}, {2'b00, m_flags});
      chk({tag, "/fv"}, {7'd0, flags_valid}, {7'd0, m_fv});
      chk({tag, "/bstall"}, {7'd0, branch_stall},
          {7'd0, branch_req & (q.size() != 0)});
   endtask

   // One isolated compare, then a check of the committed flags two edges later
   task automatic do_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [5:0] exp);
      a_in = a; b_in = b; signed_cmp = s; cmp_valid = 1'b1;
      step({tag, "_n"});
      cmp_valid = 1'b0;
      step({tag, "_n1"});
      step({tag, "_n2"});
      chk(tag, {2'b00, dut_flags()}, {2'b00, exp});
      chk({tag, "_fv"}, {7'd0, flags_valid}, 8'd1);
   endtask

   initial begin
      // Reset state, applied asynchronously before any clock edge
      branch_req = 1'b1;
      #1;
      chk("rst_flags", {2'b00, dut_flags()}, 8'h00);
      chk("rst_fv", {7'd0, flags_valid}, 8'd0);
      chk("rst_bstall", {7'd0, branch_stall}, 8'd0);
      step("rst0");
      step("rst1");
      rst = 1'b0;
      branch_req = 1'b0;
      step("idle");

      // Basic and boundary compares
      do_cmp("u5_9",      16'd5,    16'd9,    1'b0, 6'b010101);
      do_cmp("s_ffff_1",  16'hFFFF, 16'h0001, 1'b1, 6'b010101);
      do_cmp("u_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 6'b001011);
      do_cmp("s_8000_eq", 16'h8000, 16'h8000, 1'b1, 6'b100110);
      do_cmp("s_7fff_8k", 16'h7FFF, 16'h8000, 1'b1, 6'b001011);
      do_cmp("s_8k_7fff", 16'h8000, 16'h7FFF, 1'b1, 6'b010101);

      // Branch interlock while a compare is in flight
      a_in = 16'd1; b_in = 16'd2; signed_cmp = 1'b0; cmp_valid = 1'b1;
      step("bi_n");
      cmp_valid = 1'b0; branch_req = 1'b1;
      #1;
      chk("bi_n_stall", {7'd0, branch_stall}, 8'd1);
      step("bi_n1");
      chk("bi_n1_stall", {7'd0, branch_stall}, 8'd1);
      step("bi_n2");
      chk("bi_n2_stall", {7'd0, branch_stall}, 8'd0);
      branch_req = 1'b0;

      // Flush squashes the younger compare presented with it
      a_in = 16'd3; b_in = 16'd3; cmp_valid = 1'b1;
      step("fl_c1");
      a_in = 16'd1; b_in = 16'd2; flush = 1'b1;
      step("fl_c2");
      cmp_valid = 1'b0; flush = 1'b0;
      step("fl_c1_commit");
      chk("fl_eq", {2'b00, dut_flags()}, {2'b00, 6'b100110});
      step("fl_after1");
      step("fl_after2");
      chk("fl_eq_hold", {2'b00, dut_flags()}, {2'b00, 6'b100110});

      // Flush together with stall: S2 retires, stalled S1 entry squashed
      a_in = 16'd9; b_in = 16'd4; cmp_valid = 1'b1;
      step("fs_c1");
      a_in = 16'd1; b_in = 16'd8;
      step("fs_c2");
      cmp_valid = 1'b0; stall = 1'b1; flush = 1'b1;
      step("fs_edge");
      chk("fs_gt", {2'b00, dut_flags()}, {2'b00, 6'b001011});
      stall = 1'b0; flush = 1'b0;
      step("fs_after1");
      step("fs_after2");
      chk("fs_gt_hold", {2'b00, dut_flags()}, {2'b00, 6'b001011});

      // Stall with both stages full, then asynchronous reset mid-stall
      a_in = 16'd7; b_in = 16'd7; cmp_valid = 1'b1;
      step("st_c1");
      a_in = 16'd2; b_in = 16'd7;
      step("st_c2");
      stall = 1'b1; branch_req = 1'b1; a_in = 16'd9; b_in = 16'd1;
      for (int i = 0; i < 3; i++) begin
         step("st_hold");
         chk("st_flags", {2'b00, dut_flags()}, {2'b00, 6'b001011});
         chk("st_bstall", {7'd0, branch_stall}, 8'd1);
      end
      rst = 1'b1;
      #1;
      model_reset();
      chk("ar_flags", {2'b00, dut_flags()}, 8'h00);
      chk("ar_fv", {7'd0, flags_valid}, 8'd0);
      chk("ar_bstall", {7'd0, branch_stall}, 8'd0);
      stall = 1'b0; cmp_valid = 1'b0;
      step("ar_hold");
      rst = 1'b0;
      step("ar_rel1");
      step("ar_rel2");
      chk("ar_nocommit", {2'b00, dut_flags()}, 8'h00);
      branch_req = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         a_in       = 16'($urandom);
         b_in       = ($urandom_range(0, 3) == 0) ? a_in : 16'($urandom);
         signed_cmp = 1'($urandom);
         cmp_valid  = ($urandom_range(0, 9) < 6);
         stall      = ($urandom_range(0, 9) < 2);
         flush      = ($urandom_range(0, 9) == 0);
         branch_req = 1'($urandom);
         rst        = ($urandom_range(0, 99) == 0);
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
